// File: rtl/push_pop_fifo.sv
// Circular-buffer FIFO with one-cycle push/pop request pulses and registered done pulses.
// A request that cannot be serviced is held pending until the FIFO state allows it.
module push_pop_fifo #(
    parameter int DEPTH = 16,
    parameter int DATAW = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push_req,
    input  logic [DATAW-1:0]         i_push_data,
    output logic                     o_push_done,
    input  logic                     i_pop_req,
    output logic [DATAW-1:0]         o_pop_data,
    output logic                     o_pop_done,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATAW-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_push_pend;
    logic [DATAW-1:0] r_push_pend_data;
    logic             r_pop_pend;
    logic             r_overrun;
    logic             r_push_done;
    logic             r_pop_done;
    logic [DATAW-1:0] r_pop_data;

    logic             w_full;
    logic             w_empty;
    logic             w_push_act;
    logic             w_pop_act;
    logic [DATAW-1:0] w_push_word;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_ovr;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // A pending request takes priority; a new one of the same kind is dropped.
    assign w_push_act  = r_push_pend | i_push_req;
    assign w_pop_act   = r_pop_pend  | i_pop_req;
    assign w_push_word = r_push_pend ? r_push_pend_data : i_push_data;

    // Service decisions use the state before the edge, so a push on a full FIFO
    // waits one cycle even if a pop frees a slot on the same edge (and vice versa).
    assign w_do_push = w_push_act & ~w_full;
    assign w_do_pop  = w_pop_act  & ~w_empty;
    assign w_ovr     = (r_push_pend & i_push_req) | (r_pop_pend & i_pop_req);

    always_ff @(posedge i_clk) begin
        if (w_do_push)
            r_mem[r_wptr] <= w_push_word;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_count          <= '0;
            r_push_pend      <= 1'b0;
            r_push_pend_data <= '0;
            r_pop_pend       <= 1'b0;
            r_overrun        <= 1'b0;
            r_push_done      <= 1'b0;
            r_pop_done       <= 1'b0;
            r_pop_data       <= '0;
        end else begin
            r_push_done <= w_do_push;
            r_pop_done  <= w_do_pop;
            r_push_pend <= w_push_act & ~w_do_push;
            r_pop_pend  <= w_pop_act  & ~w_do_pop;
            r_overrun   <= r_overrun | w_ovr;

            if (i_push_req && !r_push_pend && !w_do_push)
                r_push_pend_data <= i_push_data;

            if (w_do_push)
                r_wptr <= r_wptr + 1'b1;

            if (w_do_pop) begin
                r_pop_data <= r_mem[r_rptr];
                r_rptr     <= r_rptr + 1'b1;
            end

            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_push_done = r_push_done;
    assign o_pop_done  = r_pop_done;
    assign o_pop_data  = r_pop_data;
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_push_pop_fifo.sv
// Directed bench for push_pop_fifo at DEPTH=4: a vector table for single-cycle
// behaviour plus hand sequences for wrap, overrun and mid-operation reset.
module tb_push_pop_fifo;

    localparam int DEPTH = 4;
    localparam int DATAW = 16;

    logic             clk;
    logic             rst_n;
    logic             push_req;
    logic [DATAW-1:0] push_data;
    logic             push_done;
    logic             pop_req;
    logic [DATAW-1:0] pop_data;
    logic             pop_done;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic             overrun;

    int n_pass = 0;
    int n_tot  = 0;

    push_pop_fifo #(.DEPTH(DEPTH), .DATAW(DATAW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_push_req  (push_req),
        .i_push_data (push_data),
        .o_push_done (push_done),
        .i_pop_req   (pop_req),
        .o_pop_data  (pop_data),
        .o_pop_done  (pop_done),
        .o_count     (count),
        .o_full      (full),
        .o_empty     (empty),
        .o_overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pu;
        logic [15:0] d;
        logic        po;
        logic        epd;
        logic        epo;
        logic [15:0] edata;
        int          ecnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic pu, input logic [15:0] d, input logic po,
                                input logic epd, input logic epo,
                                input logic [15:0] edata, input int ecnt);
        vec_t v;
        v.pu = pu; v.d = d; v.po = po;
        v.epd = epd; v.epo = epo; v.edata = edata; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One clock: drive request pulses, take the edge, release them; outputs are then stable.
    task automatic cyc(input logic pu, input logic [15:0] d, input logic po);
        push_req  = pu;
        push_data = d;
        pop_req   = po;
        @(posedge clk);
        #1;
        push_req = 1'b0;
        pop_req  = 1'b0;
    endtask

    task automatic chk_state(input string nm, input logic epd, input logic epo,
                             input logic [15:0] edata, input int ecnt);
        chk({nm, " push_done"}, 32'(push_done), 32'(epd));
        chk({nm, " pop_done"},  32'(pop_done),  32'(epo));
        chk({nm, " pop_data"},  32'(pop_data),  32'(edata));
        chk({nm, " count"},     32'(count),     32'(ecnt));
        chk({nm, " full"},      32'(full),      32'(ecnt == DEPTH));
        chk({nm, " empty"},     32'(empty),     32'(ecnt == 0));
    endtask

    initial begin
        rst_n = 1'b0; push_req = 1'b0; pop_req = 1'b0; push_data = '0;

        // basic order
        tbl.push_back(mk(1, 16'h1111, 0, 1, 0, 16'h0000, 1));
        tbl.push_back(mk(1, 16'h2222, 0, 1, 0, 16'h0000, 2));
        tbl.push_back(mk(1, 16'h3333, 0, 1, 0, 16'h0000, 3));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h1111, 2));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h2222, 1));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h3333, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 16'h3333, 0));
        // simultaneous push/pop in the middle
        tbl.push_back(mk(1, 16'h0101, 0, 1, 0, 16'h3333, 1));
        tbl.push_back(mk(1, 16'h0202, 0, 1, 0, 16'h3333, 2));
        tbl.push_back(mk(1, 16'h7777, 1, 1, 1, 16'h0101, 2));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h0202, 1));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h7777, 0));
        // push while full is held pending
        tbl.push_back(mk(1, 16'hA000, 0, 1, 0, 16'h7777, 1));
        tbl.push_back(mk(1, 16'hA001, 0, 1, 0, 16'h7777, 2));
        tbl.push_back(mk(1, 16'hA002, 0, 1, 0, 16'h7777, 3));
        tbl.push_back(mk(1, 16'hA003, 0, 1, 0, 16'h7777, 4));
        tbl.push_back(mk(1, 16'hBEEF, 0, 0, 0, 16'h7777, 4));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'hA000, 3));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 16'hA000, 4));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'hA001, 3));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'hA002, 2));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'hA003, 1));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'hBEEF, 0));
        // pop while empty is held pending
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 16'hBEEF, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 16'hBEEF, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 16'hBEEF, 0));
        tbl.push_back(mk(1, 16'h5A5A, 0, 1, 0, 16'hBEEF, 1));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h5A5A, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 16'h5A5A, 0));
        // simultaneous on empty: push now, pop next edge
        tbl.push_back(mk(1, 16'h1234, 1, 1, 0, 16'h5A5A, 1));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h1234, 0));
        // simultaneous on full: pop now, push next edge
        tbl.push_back(mk(1, 16'h00C0, 0, 1, 0, 16'h1234, 1));
        tbl.push_back(mk(1, 16'h00C1, 0, 1, 0, 16'h1234, 2));
        tbl.push_back(mk(1, 16'h00C2, 0, 1, 0, 16'h1234, 3));
        tbl.push_back(mk(1, 16'h00C3, 0, 1, 0, 16'h1234, 4));
        tbl.push_back(mk(1, 16'h00CC, 1, 0, 1, 16'h00C0, 3));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h00C0, 4));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h00C1, 3));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h00C2, 2));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h00C3, 1));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h00CC, 0));

        // reset state
        #12;
        chk_state("reset", 0, 0, 16'h0000, 0);
        chk("reset overrun", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            begin
                cyc(tbl[i].pu, tbl[i].d, tbl[i].po);
                chk_state($sformatf("row%0d", i), tbl[i].epd, tbl[i].epo, tbl[i].edata, tbl[i].ecnt);
            end
        chk("table overrun", 32'(overrun), 32'd0);

        // ten words through, pointers wrap repeatedly
        for (int i = 0; i < 10; i++) begin
            cyc(1, 16'h9000 + 16'(i), 0);
            chk($sformatf("wrap%0d push_done", i), 32'(push_done), 32'd1);
            cyc(0, 16'h0000, 1);
            chk($sformatf("wrap%0d pop_data", i), 32'(pop_data), 32'h9000 + 32'(i));
            chk($sformatf("wrap%0d pop_done", i), 32'(pop_done), 32'd1);
        end

        // second pop while one is pending: dropped, overrun set
        cyc(0, 16'h0000, 1);
        chk("ovr first pop_done", 32'(pop_done), 32'd0);
        cyc(0, 16'h0000, 1);
        chk("ovr flag", 32'(overrun), 32'd1);
        chk("ovr second pop_done", 32'(pop_done), 32'd0);
        cyc(1, 16'h6666, 0);
        chk("ovr push_done", 32'(push_done), 32'd1);
        cyc(0, 16'h0000, 0);
        chk_state("ovr serviced", 0, 1, 16'h6666, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 16'h0000, 0);
            chk($sformatf("ovr no extra pop_done%0d", i), 32'(pop_done), 32'd0);
        end
        chk("ovr sticky", 32'(overrun), 32'd1);

        // mid-operation reset: three words stored plus a pending push
        cyc(1, 16'h00D0, 0);
        cyc(1, 16'h00D1, 0);
        cyc(1, 16'h00D2, 0);
        cyc(1, 16'h00D3, 0);
        cyc(1, 16'h00D4, 0);
        cyc(0, 16'h0000, 1);
        chk_state("pre-reset", 0, 1, 16'h00D0, 3);
        #2 rst_n = 1'b0;
        #1;
        chk_state("async reset", 0, 0, 16'h0000, 0);
        chk("async reset overrun", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 16'h0000, 0);
            chk_state($sformatf("post-reset%0d", i), 0, 0, 16'h0000, 0);
        end
        cyc(1, 16'h4242, 0);
        chk("post-reset first push", 32'(push_done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
